wash_sequencer: RTL
===================

// Module: wash_sequencer
// PURPOSE
// Programme controller for the washing register machine; drives the 8-bit down-timer and consumes its expiry.
// - Runs FILL -> WASH -> DRAIN once, then repeats FILL -> WASH -> DRAIN RINSES times, then SPIN.
// - Each timed phase loads the timer (timer_set/timer_load) and waits for timer_irq.
// - Water sensors end FILL and DRAIN early; a timer expiry before the sensor responds is a FAULT.
// PARAMETERS
// FILL_TMO  200  FILL timeout in cycles (8-bit); expiry before water_full -> FAULT
// WASH_T    150  WASH/rinse agitation duration (8-bit)
// DRAIN_TMO 200  DRAIN timeout (8-bit); expiry before water_empty -> FAULT
// SPIN_T    100  SPIN duration (8-bit)
// RINSES    1    rinse passes after the wash pass (0..3)
// PORTS
// clk          in   1  clock, rising edge
// rst          in   1  asynchronous, active-high reset
// start        in   1  start programme; honoured only in IDLE
// abort        in   1  stop immediately to IDLE; also clears FAULT
// water_full   in   1  level sensor: drum full
// water_empty  in   1  level sensor: drum empty
// timer_irq    in   1  timer expiry pulse (timer count == 0)
// timer_set    out  8  duration presented to the timer
// timer_load   out  1  one-cycle timer load strobe
// valve_in     out  1  inlet valve (FILL)
// pump_out     out  1  drain pump (DRAIN, SPIN)
// motor_on     out  1  drum motor (WASH, SPIN)
// motor_fast   out  1  spin speed (SPIN)
// phase        out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 SPIN, 7 FAULT
// pass         out  2  current pass index (0 = wash, 1..RINSES = rinse)
// done         out  1  one-cycle pulse when SPIN completes
// fault        out  1  high while in FAULT
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0, including pass=0, timer_set=0 and timer_load=0. The armed flag is 0.
// - All outputs are registered or are decodes of registered state; no input-to-output combinational path.
// - Entering FILL/WASH/DRAIN/SPIN: during the first cycle in the state, timer_load=1 and timer_set=phase value. armed=0.
// - timer_irq is ignored in that load cycle, because the timer still holds its stale count. armed=1 from the next cycle.
// - Timer timing: a load in cycle c gives timer_irq in cycle c+1+N. A timed state therefore lasts N+2 cycles; N=0 is legal.
// - IDLE: start=1 -> FILL, pass=0. Otherwise hold.
// - FILL: an armed cycle with water_full=1 -> WASH. An armed cycle with timer_irq=1 and water_full=0 -> FAULT.
//   Sensor and timer in the same cycle: the sensor wins.
// - WASH: armed & timer_irq -> DRAIN.
// - DRAIN: an armed cycle with water_empty=1 selects the next state from pass.
//   If pass==RINSES -> SPIN; otherwise pass+1 and -> FILL.
//   armed & timer_irq & ~water_empty -> FAULT. The sensor wins a tie.
// - SPIN: armed & timer_irq -> IDLE, done=1 for exactly one cycle, pass=0.
// - FAULT: all actuators 0, fault=1. Exits only on abort=1 -> IDLE.
// - abort=1 in any non-IDLE state -> IDLE next cycle. Actuators 0, pass=0, no timer_load, no done.
//   abort has priority over every other event.
// - start outside IDLE is ignored. start and abort together in IDLE -> stay IDLE.
// - The timer is never reloaded mid-state, and timer_load is never asserted in IDLE or FAULT.
// - Async reset mid-programme returns to the reset state at once; actuators drop without waiting for a clock.
// TESTING
// - WASH_T=3, RINSES=0, sensors asserted 2 cycles into FILL/DRAIN -> phases 1,2,3,4,0.
//   WASH lasts 5 cycles; done pulses once; timer_load pulses 4 times.
// - FILL_TMO=5, water_full held 0 -> timer_irq 6 cycles after load -> FAULT, fault=1, valve_in=0.
//   abort -> IDLE.
// - RINSES=2 -> pass runs 0,1,2 over three FILL/WASH/DRAIN rounds, then SPIN. pass=0 after done.
// - timer_irq forced high during each load cycle -> ignored; state is unchanged that cycle.
// - water_full and timer_irq in the same armed FILL cycle -> WASH, not FAULT.
//   The same applies to water_empty in DRAIN.
// - abort mid-WASH, then rst mid-SPIN -> IDLE with all outputs 0. start while busy has no effect.

Source files
------------

// File: rtl/wash_sequencer_if.sv
// rtl/wash_sequencer_if.sv - sensor, timer and actuator bundle of the wash sequencer
interface wash_sequencer_if;
    logic       start;
    logic       abort;
    logic       water_full;
    logic       water_empty;
    logic       timer_irq;
    logic [7:0] timer_set;
    logic       timer_load;
    logic       valve_in;
    logic       pump_out;
    logic       motor_on;
    logic       motor_fast;
    logic [2:0] phase;
    logic [1:0] pass;
    logic       done;
    logic       fault;

    modport master (
        input  start, abort, water_full, water_empty, timer_irq,
        output timer_set, timer_load, valve_in, pump_out, motor_on, motor_fast,
               phase, pass, done, fault
    );

    modport slave (
        output start, abort, water_full, water_empty, timer_irq,
        input  timer_set, timer_load, valve_in, pump_out, motor_on, motor_fast,
               phase, pass, done, fault
    );
endinterface

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - FILL/WASH/DRAIN x (1+RINSES) then SPIN programme controller
module wash_sequencer #(
    parameter int unsigned FILL_TMO  = 200,
    parameter int unsigned WASH_T    = 150,
    parameter int unsigned DRAIN_TMO = 200,
    parameter int unsigned SPIN_T    = 100,
    parameter int unsigned RINSES    = 1
) (
    input logic              clk,
    input logic              rst,
    wash_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WASH  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_SPIN  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd7;

    localparam logic [7:0] FILL_TMO_L  = 8'(FILL_TMO);
    localparam logic [7:0] WASH_T_L    = 8'(WASH_T);
    localparam logic [7:0] DRAIN_TMO_L = 8'(DRAIN_TMO);
    localparam logic [7:0] SPIN_T_L    = 8'(SPIN_T);
    localparam logic [1:0] RINSES_L    = 2'(RINSES);

    logic [2:0] state_q, state_d;
    logic       armed_q, armed_d;
    logic       load_q, load_d;
    logic [7:0] set_q, set_d;
    logic [1:0] pass_q, pass_d;
    logic       done_q, done_d;
    logic       enter;
    logic       timed;

    assign timed = (state_q == S_FILL) || (state_q == S_WASH) ||
                   (state_q == S_DRAIN) || (state_q == S_SPIN);

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        enter   = 1'b0;
        // abort outranks every sensor and timer event
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pass_d  = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d = S_FILL;
                        pass_d  = 2'd0;
                        enter   = 1'b1;
                    end
                end
                S_FILL: begin
                    if (armed_q && bus.water_full) begin
                        state_d = S_WASH;
                        enter   = 1'b1;
                    end else if (armed_q && bus.timer_irq) begin
                        state_d = S_FAULT;
                    end
                end
                S_WASH: begin
                    if (armed_q && bus.timer_irq) begin
                        state_d = S_DRAIN;
                        enter   = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (armed_q && bus.water_empty) begin
                        enter = 1'b1;
                        if (pass_q == RINSES_L) begin
                            state_d = S_SPIN;
                        end else begin
                            state_d = S_FILL;
                            pass_d  = pass_q + 2'd1;
                        end
                    end else if (armed_q && bus.timer_irq) begin
                        state_d = S_FAULT;
                    end
                end
                S_SPIN: begin
                    if (armed_q && bus.timer_irq) begin
                        state_d = S_IDLE;
                        pass_d  = 2'd0;
                        done_d  = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                    pass_d  = 2'd0;
                end
            endcase
        end

        // the load cycle still sees the timer's stale count, so arm one cycle later
        load_d  = enter;
        armed_d = timed && !enter && (state_d == state_q);
        set_d   = 8'd0;
        if (enter) begin
            case (state_d)
                S_FILL:  set_d = FILL_TMO_L;
                S_WASH:  set_d = WASH_T_L;
                S_DRAIN: set_d = DRAIN_TMO_L;
                S_SPIN:  set_d = SPIN_T_L;
                default: set_d = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            load_q  <= 1'b0;
            set_q   <= 8'd0;
            pass_q  <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            load_q  <= load_d;
            set_q   <= set_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    // actuators decode the state register so an async reset drops them at once
    assign bus.phase      = state_q;
    assign bus.valve_in   = (state_q == S_FILL);
    assign bus.pump_out   = (state_q == S_DRAIN) || (state_q == S_SPIN);
    assign bus.motor_on   = (state_q == S_WASH) || (state_q == S_SPIN);
    assign bus.motor_fast = (state_q == S_SPIN);
    assign bus.fault      = (state_q == S_FAULT);
    assign bus.timer_load = load_q;
    assign bus.timer_set  = set_q;
    assign bus.pass       = pass_q;
    assign bus.done       = done_q;
endmodule
